// File: rtl/lreport_gen_if.sv
// lreport_gen_if: UM packet bus in and out of the report injector, plus the upstream ready.
// Latency: none (wires only).
// Backpressure: pktin_ready gates the start of new upstream packets.
interface lreport_gen_if;
  logic         in_data_wr;
  logic [133:0] in_data;
  logic         in_valid_wr;
  logic         in_valid;
  logic         pktin_ready;
  logic         out_data_wr;
  logic [133:0] out_data;
  logic         out_valid_wr;
  logic         out_valid;

  // Upstream/downstream side: drives the input bus, observes ready and the output bus.
  modport master (
    output in_data_wr, in_data, in_valid_wr, in_valid,
    input  pktin_ready, out_data_wr, out_data, out_valid_wr, out_valid
  );

  // Injector side.
  modport slave (
    input  in_data_wr, in_data, in_valid_wr, in_valid,
    output pktin_ready, out_data_wr, out_data, out_valid_wr, out_valid
  );
endinterface

// File: rtl/lreport_gen.sv
// lreport_gen: forwards UM packets (source MID rewritten on headers) and injects a periodic PTP report between packets.
// Latency: forwarded words appear 1 cycle after acceptance; on an idle bus the report head leaves 3 cycles after the trigger.
// Backpressure: pktin_ready drops from ARB until GAP ends; words arriving during REP/GAP are dropped.
// Build option: define LREPORT_OVERRUN_EN to count triggers that hit a still-pending report (carried in W4).
module lreport_gen #(
  parameter int unsigned NUM_CNT    = 14,
  parameter int unsigned PERIOD_BIT = 22,
  parameter logic [47:0] PHASE      = 48'hFF,
  parameter logic [7:0]  SRC_MID    = 8'd1,
  parameter logic [47:0] CNC_MAC    = 48'h010203040506,
  parameter int unsigned GAP        = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  lreport_gen_if.slave            bus,
  input  logic [47:0]             precision_time,
  input  logic [47:0]             local_mac,
  input  logic                    upd_toggle,
  input  logic [NUM_CNT*64-1:0]   cnt_vec,
  output logic [15:0]             report_seq,
  output logic                    report_busy
);

  // Report geometry: 6 fixed words plus one word per counter pair.
  localparam int unsigned NP   = (NUM_CNT + 1) / 2;
  localparam int unsigned NW   = 6 + NP;
  localparam int unsigned CPW  = NP * 128;
  localparam logic [15:0] LEN  = 16'(NW * 16);
  localparam logic [15:0] PLEN = 16'((NW - 2) * 16);
  localparam int unsigned IW   = $clog2(NW);
  localparam int unsigned GW   = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PASS,
    S_ARB,
    S_REP,
    S_GAP
  } state_t;

  state_t state, state_nxt;

  // Trigger / pending bookkeeping
  logic                  trig;
  logic                  pending;
  logic [47:0]           ts_latch;

  // Report context
  logic [47:0]           snapshot_ts;
  logic [NUM_CNT*64-1:0] cnt_snap;
  logic [IW-1:0]         widx, widx_n;
  logic [GW-1:0]         gap_cnt, gap_n;
  logic                  upd_seen;
  logic [15:0]           seq_q;
  logic [15:0]           ovr16;

  // Registered outputs
  logic                  out_data_wr_q, out_valid_wr_q, out_valid_q, ready_q;
  logic [133:0]          out_data_q;

  // Next-cycle values / strobes from the FSM
  logic                  od_wr_n, ovw_n, ov_n;
  logic [133:0]          od_n;
  logic                  ready_clr, ready_set, pend_clr, snap_ld, upd_ld, seq_inc;
  logic [133:0]          hdr_fwd;

  // Counter pair selection and report word
  logic [CPW-1:0]        cnt_pad;
  logic [IW-1:0]         pidx;
  logic [127:0]          pair;
  logic [3:0]            rep_type;
  logic [133:0]          rep_word;

  assign trig = (precision_time[PERIOD_BIT-1:0] == PHASE[PERIOD_BIT-1:0]);

  assign bus.out_data_wr  = out_data_wr_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_valid_wr = out_valid_wr_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.pktin_ready  = ready_q;
  assign report_seq       = seq_q;
  assign report_busy      = (state == S_ARB) || (state == S_REP) || (state == S_GAP);

  // Periodic trigger: newest timestamp wins; a trigger beats the ARB clear of pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= 1'b0;
      ts_latch <= '0;
    end else if (trig) begin
      pending  <= 1'b1;
      ts_latch <= precision_time;
    end else if (pend_clr) begin
      pending  <= 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state and per-cycle actions; headers accepted in IDLE/ARB get the local MID.
  always_comb begin
    state_nxt = state;
    od_wr_n   = 1'b0;
    od_n      = '0;
    ovw_n     = 1'b0;
    ov_n      = 1'b0;
    ready_clr = 1'b0;
    ready_set = 1'b0;
    pend_clr  = 1'b0;
    snap_ld   = 1'b0;
    upd_ld    = 1'b0;
    seq_inc   = 1'b0;
    widx_n    = widx;
    gap_n     = gap_cnt;
    hdr_fwd   = bus.in_data;
    hdr_fwd[87:80] = SRC_MID;
    case (state)
      S_IDLE: begin
        if (bus.in_data_wr) begin
          od_wr_n   = 1'b1;
          od_n      = hdr_fwd;
          ovw_n     = bus.in_valid_wr;
          ov_n      = bus.in_valid;
          state_nxt = S_PASS;
        end else if (pending) begin
          ready_clr = 1'b1;
          state_nxt = S_ARB;
        end
      end
      S_PASS: begin
        od_wr_n = bus.in_data_wr;
        od_n    = bus.in_data_wr ? bus.in_data : '0;
        ovw_n   = bus.in_valid_wr;
        ov_n    = bus.in_valid;
        if (bus.in_data_wr && (bus.in_data[133:132] == 2'b10)) state_nxt = S_IDLE;
      end
      S_ARB: begin
        // A packet launched just before ready fell still has to go first.
        if (bus.in_data_wr) begin
          od_wr_n   = 1'b1;
          od_n      = hdr_fwd;
          ovw_n     = bus.in_valid_wr;
          ov_n      = bus.in_valid;
          state_nxt = S_PASS;
        end else begin
          pend_clr  = 1'b1;
          snap_ld   = 1'b1;
          widx_n    = '0;
          state_nxt = S_REP;
        end
      end
      S_REP: begin
        od_wr_n = 1'b1;
        od_n    = rep_word;
        if (widx == IW'(2)) upd_ld = 1'b1;
        if (widx == IW'(NW - 1)) begin
          ovw_n     = 1'b1;
          ov_n      = 1'b1;
          seq_inc   = 1'b1;
          gap_n     = '0;
          state_nxt = S_GAP;
        end else begin
          widx_n = widx + IW'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt == GW'(GAP - 1)) begin
          ready_set = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          gap_n = gap_cnt + GW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Registered output bus and upstream ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_wr_q  <= 1'b0;
      out_data_q     <= '0;
      out_valid_wr_q <= 1'b0;
      out_valid_q    <= 1'b0;
      ready_q        <= 1'b1;
    end else begin
      out_data_wr_q  <= od_wr_n;
      out_data_q     <= od_n;
      out_valid_wr_q <= ovw_n;
      out_valid_q    <= ov_n;
      if (ready_clr)      ready_q <= 1'b0;
      else if (ready_set) ready_q <= 1'b1;
    end
  end

  // Report context: snapshot at ARB exit, word/gap counters, update tracking, sequence number.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snapshot_ts <= '0;
      cnt_snap    <= '0;
      widx        <= '0;
      gap_cnt     <= '0;
      upd_seen    <= 1'b0;
      seq_q       <= '0;
    end else begin
      if (snap_ld) begin
        snapshot_ts <= ts_latch;
        cnt_snap    <= cnt_vec;
      end
      widx    <= widx_n;
      gap_cnt <= gap_n;
      if (upd_ld)  upd_seen <= upd_toggle;
      if (seq_inc) seq_q    <= seq_q + 16'd1;
    end
  end

  // Pad the snapshot to whole 128-bit pairs (missing odd counter reads as zero) and pick the current pair.
  always_comb begin
    cnt_pad = '0;
    cnt_pad[NUM_CNT*64-1:0] = cnt_snap;
    pidx = (widx >= IW'(6)) ? (widx - IW'(6)) : '0;
    pair = cnt_pad[pidx*128 +: 128];
  end

  // Report word for the current index; the last word carries the tail flag.
  always_comb begin
    rep_type = (upd_toggle != upd_seen) ? 4'hE : 4'hF;
    rep_word = {2'b11, 4'h0, pair[63:0], pair[127:64]};
    case (widx)
      IW'(0): rep_word = {2'b01, 4'h0, 1'b1, 15'h0, LEN, 8'd128, SRC_MID, 32'h0, snapshot_ts};
      IW'(1): rep_word = {2'b11, 4'h0, 128'h0};
      IW'(2): rep_word = {2'b11, 4'h0, CNC_MAC, local_mac, 16'h88F7, 4'h0, rep_type, 8'h0};
      IW'(3): rep_word = {2'b11, 4'h0, PLEN, 112'h0};
      IW'(4): rep_word = {2'b11, 4'h0, 96'h0, seq_q, ovr16};
      IW'(5): rep_word = {2'b11, 4'h0, 32'h0, snapshot_ts, 48'h0};
      default: ;
    endcase
    if (widx == IW'(NW - 1)) rep_word[133:132] = 2'b10;
  end

`ifdef LREPORT_OVERRUN_EN
  logic [15:0] ovr_cnt;

  // Saturating overrun count; cleared as W4 leaves, a coincident overrun restarts it at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_cnt <= '0;
    end else if ((state == S_REP) && (widx == IW'(4))) begin
      ovr_cnt <= (trig && pending) ? 16'd1 : 16'd0;
    end else if (trig && pending && (ovr_cnt != 16'hFFFF)) begin
      ovr_cnt <= ovr_cnt + 16'd1;
    end
  end

  assign ovr16 = ovr_cnt;
`else
  assign ovr16 = 16'h0;
`endif

endmodule

// File: tb/tb_lreport_gen.sv
`timescale 1ns/1ps
module tb_lreport_gen;
  localparam int          NUM_CNT    = 3;
  localparam int          PERIOD_BIT = 8;
  localparam int          GAP        = 2;
  localparam logic [47:0] PHASE      = 48'hFF;
  localparam logic [7:0]  SRC_MID    = 8'h5A;
  localparam logic [47:0] CNC_MAC    = 48'h010203040506;
  localparam int          NW         = 6 + (NUM_CNT + 1) / 2;
  localparam logic [47:0] IDLE_T     = 48'h0000_0000_1200;
`ifdef LREPORT_OVERRUN_EN
  localparam logic [15:0] OVR_EXP    = 16'd1;
`else
  localparam logic [15:0] OVR_EXP    = 16'd0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [47:0]           precision_time;
  logic [47:0]           local_mac;
  logic                  upd_toggle;
  logic [NUM_CNT*64-1:0] cnt_vec;
  logic [15:0]           report_seq;
  logic                  report_busy;

  lreport_gen_if bus();

  lreport_gen #(
    .NUM_CNT(NUM_CNT), .PERIOD_BIT(PERIOD_BIT), .PHASE(PHASE),
    .SRC_MID(SRC_MID), .CNC_MAC(CNC_MAC), .GAP(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .precision_time(precision_time), .local_mac(local_mac),
    .upd_toggle(upd_toggle), .cnt_vec(cnt_vec),
    .report_seq(report_seq), .report_busy(report_busy)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [15:0]  m_seq;
  logic         m_upd_seen;
  logic [63:0]  cnt_arr [NUM_CNT];
  logic [135:0] got_q [$];
  logic [135:0] exp_q [$];

  // Collect every written output word as {valid_wr, valid, data}.
  always @(negedge clk)
    if (rst_n && bus.out_data_wr)
      got_q.push_back({bus.out_valid_wr, bus.out_valid, bus.out_data});

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    bus.in_data_wr  = 1'b0;
    bus.in_data     = '0;
    bus.in_valid_wr = 1'b0;
    bus.in_valid    = 1'b0;
    precision_time  = IDLE_T;
  endtask

  function automatic logic [47:0] rand_ts();
    logic [47:0] t;
    t = {16'($urandom), 32'($urandom)};
    t[7:0] = 8'hFF;
    return t;
  endfunction

  task automatic set_cnts();
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_arr[i] = {$urandom, $urandom};
      cnt_vec[64*i +: 64] = cnt_arr[i];
    end
  endtask

  task automatic fire(output logic [47:0] ts);
    ts = rand_ts();
    precision_time = ts;
    cyc();
    precision_time = IDLE_T;
  endtask

  // Expected report from the field layout; type/sequence follow the model state.
  task automatic push_report(input logic [47:0] ts, input logic [15:0] ovr);
    logic [3:0]  ty;
    logic [63:0] a, b;
    ty = (upd_toggle != m_upd_seen) ? 4'hE : 4'hF;
    m_upd_seen = upd_toggle;
    exp_q.push_back({2'b00, 2'b01, 4'h0, 1'b1, 15'h0, 16'(NW*16), 8'd128, SRC_MID, 32'h0, ts});
    exp_q.push_back({2'b00, 2'b11, 4'h0, 128'h0});
    exp_q.push_back({2'b00, 2'b11, 4'h0, CNC_MAC, local_mac, 16'h88F7, 4'h0, ty, 8'h0});
    exp_q.push_back({2'b00, 2'b11, 4'h0, 16'((NW-2)*16), 112'h0});
    exp_q.push_back({2'b00, 2'b11, 4'h0, 96'h0, m_seq, ovr});
    exp_q.push_back({2'b00, 2'b11, 4'h0, 32'h0, ts, 48'h0});
    for (int j = 0; j < (NUM_CNT + 1) / 2; j++) begin
      a = cnt_arr[2*j];
      b = (2*j + 1 < NUM_CNT) ? cnt_arr[2*j+1] : 64'h0;
      if (j == (NUM_CNT + 1) / 2 - 1) exp_q.push_back({2'b11, 2'b10, 4'h0, a, b});
      else                           exp_q.push_back({2'b00, 2'b11, 4'h0, a, b});
    end
    m_seq = m_seq + 16'd1;
  endtask

  // Drive an nw-word packet; triggers fire alongside words fa / fb (-1 for none).
  task automatic send_pkt(input int nw, input int fa, input int fb,
                          output logic [47:0] ts_a, output logic [47:0] ts_b);
    logic [127:0] w;
    logic [1:0]   fl;
    logic [133:0] e;
    ts_a = '0;
    ts_b = '0;
    for (int k = 0; k < nw; k++) begin
      w  = {$urandom, $urandom, $urandom, $urandom};
      fl = (k == 0) ? 2'b01 : ((k == nw - 1) ? 2'b10 : 2'b11);
      bus.in_data_wr  = 1'b1;
      bus.in_data     = {fl, 4'hF, w};
      bus.in_valid_wr = (k == nw - 1);
      bus.in_valid    = (k == nw - 1);
      if (k == fa)      begin ts_a = rand_ts(); precision_time = ts_a; end
      else if (k == fb) begin ts_b = rand_ts(); precision_time = ts_b; end
      else              precision_time = IDLE_T;
      e = {fl, 4'hF, w};
      if (k == 0) e[87:80] = SRC_MID;
      exp_q.push_back({(k == nw - 1), (k == nw - 1), e});
      cyc();
    end
    idle_inputs();
  endtask

  task automatic drain();
    for (int c = 0; c < 300 && got_q.size() < exp_q.size(); c++) cyc();
    repeat (GAP + 6) cyc();
  endtask

  task automatic test_reset();
    idle_inputs();
    local_mac  = {16'($urandom), 32'($urandom)};
    upd_toggle = 1'b0;
    cnt_vec    = '0;
    m_seq      = 16'd0;
    m_upd_seen = 1'b0;
    rst_n      = 1'b0;
    repeat (3) cyc();
    n_checks++; if (bus.out_data_wr !== 1'b0)  begin n_fail++; $display("FAIL rst_out_data_wr: got %b expected 0", bus.out_data_wr); end
    n_checks++; if (bus.out_data !== 134'h0)   begin n_fail++; $display("FAIL rst_out_data: got %h expected 0", bus.out_data); end
    n_checks++; if (bus.out_valid_wr !== 1'b0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b%b expected 00", bus.out_valid_wr, bus.out_valid); end
    n_checks++; if (bus.pktin_ready !== 1'b1)  begin n_fail++; $display("FAIL rst_ready: got %b expected 1", bus.pktin_ready); end
    n_checks++; if (report_seq !== 16'h0)      begin n_fail++; $display("FAIL rst_seq: got %h expected 0", report_seq); end
    n_checks++; if (report_busy !== 1'b0)      begin n_fail++; $display("FAIL rst_busy: got %b expected 0", report_busy); end
    rst_n = 1'b1;
    repeat (2) cyc();
  endtask

  // T1: report on an idle bus, plus ready/busy window length.
  task automatic test_report_idle();
    logic [47:0] ts;
    int low, busy;
    set_cnts();
    ts = rand_ts();
    precision_time = ts;
    push_report(ts, 16'h0);
    cyc();
    precision_time = IDLE_T;
    low = 0; busy = 0;
    for (int c = 0; c < NW + GAP + 8; c++) begin
      cyc();
      if (bus.pktin_ready === 1'b0) low++;
      if (report_busy === 1'b1) busy++;
    end
    n_checks++; if (low != NW + GAP + 1)  begin n_fail++; $display("FAIL t1_ready_low_cycles: got %0d expected %0d", low, NW + GAP + 1); end
    n_checks++; if (busy != NW + GAP + 1) begin n_fail++; $display("FAIL t1_busy_cycles: got %0d expected %0d", busy, NW + GAP + 1); end
    drain();
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL t1_count: got %0d words expected %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[k]) begin
      n_checks++;
      if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL t1_word%0d: got %h expected %h", k, (k < got_q.size()) ? got_q[k] : 136'h0, exp_q[k]); end
    end
    n_checks++; if (report_seq !== m_seq) begin n_fail++; $display("FAIL t1_seq: got %h expected %h", report_seq, m_seq); end
    got_q.delete(); exp_q.delete();
  endtask

  // T2: a packet starts in the trigger cycle; report follows its tail.
  task automatic test_pkt_pending();
    logic [47:0] ts, d;
    set_cnts();
    send_pkt(4, 0, -1, ts, d);
    push_report(ts, 16'h0);
    drain();
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL t2_count: got %0d words expected %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[k]) begin
      n_checks++;
      if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL t2_word%0d: got %h expected %h", k, (k < got_q.size()) ? got_q[k] : 136'h0, exp_q[k]); end
    end
    n_checks++; if (bus.pktin_ready !== 1'b1) begin n_fail++; $display("FAIL t2_ready_after: got %b expected 1", bus.pktin_ready); end
    got_q.delete(); exp_q.delete();
  endtask

  // T3: header lands exactly in the arbitration cycle.
  task automatic test_arb_header();
    logic [47:0] ts, d1, d2;
    set_cnts();
    fire(ts);
    cyc();
    n_checks++; if (bus.pktin_ready !== 1'b0) begin n_fail++; $display("FAIL t3_ready_in_arb: got %b expected 0", bus.pktin_ready); end
    send_pkt(3, -1, -1, d1, d2);
    push_report(ts, 16'h0);
    drain();
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL t3_count: got %0d words expected %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[k]) begin
      n_checks++;
      if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL t3_word%0d: got %h expected %h", k, (k < got_q.size()) ? got_q[k] : 136'h0, exp_q[k]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  // T4: update toggle marks exactly one report.
  task automatic test_update();
    logic [47:0] ts;
    upd_toggle = ~upd_toggle;
    for (int r = 0; r < 2; r++) begin
      set_cnts();
      fire(ts);
      push_report(ts, 16'h0);
      drain();
      n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL t4_count%0d: got %0d words expected %0d", r, got_q.size(), exp_q.size()); end
      foreach (exp_q[k]) begin
        n_checks++;
        if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL t4_r%0d_word%0d: got %h expected %h", r, k, (k < got_q.size()) ? got_q[k] : 136'h0, exp_q[k]); end
      end
      got_q.delete(); exp_q.delete();
    end
    n_checks++; if (report_seq !== m_seq) begin n_fail++; $display("FAIL t4_seq: got %h expected %h", report_seq, m_seq); end
  endtask

  // T5: two triggers during one long packet; newest timestamp and overrun count.
  task automatic test_overrun();
    logic [47:0] ts1, ts2;
    set_cnts();
    send_pkt(10, 2, 6, ts1, ts2);
    push_report(ts2, OVR_EXP);
    drain();
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL t5_count: got %0d words expected %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[k]) begin
      n_checks++;
      if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL t5_word%0d: got %h expected %h", k, (k < got_q.size()) ? got_q[k] : 136'h0, exp_q[k]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  // T6: reset asserted while W4 is on the bus, then a clean full report.
  task automatic test_reset_mid();
    logic [47:0] ts;
    set_cnts();
    got_q.delete(); exp_q.delete();
    fire(ts);
    for (int c = 0; c < 50 && got_q.size() < 5; c++) begin @(negedge clk); #1; end
    n_checks++; if (got_q.size() != 5) begin n_fail++; $display("FAIL t6_reach_w4: got %0d words expected 5", got_q.size()); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.out_data_wr !== 1'b0) begin n_fail++; $display("FAIL t6_out_data_wr: got %b expected 0", bus.out_data_wr); end
    n_checks++; if (bus.out_data !== 134'h0)  begin n_fail++; $display("FAIL t6_out_data: got %h expected 0", bus.out_data); end
    n_checks++; if (bus.pktin_ready !== 1'b1) begin n_fail++; $display("FAIL t6_ready: got %b expected 1", bus.pktin_ready); end
    n_checks++; if (report_seq !== 16'h0)     begin n_fail++; $display("FAIL t6_seq: got %h expected 0", report_seq); end
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (2) cyc();
    got_q.delete(); exp_q.delete();
    m_seq = 16'd0;
    m_upd_seen = 1'b0;
    set_cnts();
    fire(ts);
    push_report(ts, 16'h0);
    drain();
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL t6_count: got %0d words expected %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[k]) begin
      n_checks++;
      if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL t6_word%0d: got %h expected %h", k, (k < got_q.size()) ? got_q[k] : 136'h0, exp_q[k]); end
    end
    n_checks++; if (report_seq !== m_seq) begin n_fail++; $display("FAIL t6_seq_after: got %h expected %h", report_seq, m_seq); end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_report_idle();
    test_pkt_pending();
    test_arb_header();
    test_update();
    test_overrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
